bram_master: RTL and testbench

Command-driven initiator for the single-port block RAM's shared bidirectional data bus. Accepts one read or write command at a time over a valid/ready interface, sequences the RAM's `we`/`addr`/`data` pins, and returns each result over a valid/ready response channel. Sits between the 6502 core glue (or a test/loader engine) and a block RAM instance, and owns bus turnaround so that only one side ever drives `mem_data`.

---
 rtl/bram_master.sv | 148 ++++++++++++++
 tb/tb_bram_master.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_master.sv
// Command-driven initiator for a single-port block RAM with a shared bidirectional data bus.
// Define BRAM_MASTER_RDBACK_EN to follow every write with a verifying read-back.
module bram_master #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int ADDRW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [ADDRW-1:0] cmd_addr,
    input  logic [WIDTH-1:0] cmd_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             mem_we,
    output logic [ADDRW-1:0] mem_addr,
    inout  wire  [WIDTH-1:0] mem_data
);

    // cmd: transfer on an edge where cmd_valid & cmd_ready; rsp: transfer on an edge
    // where rsp_valid & rsp_ready; valid is held with stable payload until the transfer.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        RD_ADDR = 3'd2,
        RD_DATA = 3'd3,
        RSP     = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDRW-1:0]   addr_q, addr_d;
    logic [WIDTH-1:0]   wdata_q, wdata_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
`ifdef BRAM_MASTER_RDBACK_EN
    logic               rsp_err_q, rsp_err_d;
    logic               vfy_q, vfy_d;
`endif

    // The master owns the bus only while the RAM is being written.
    assign mem_data  = mem_we_q ? wdata_q : {WIDTH{1'bz}};
    assign cmd_ready = (state_q == IDLE);
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
`ifdef BRAM_MASTER_RDBACK_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_we_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
`ifdef BRAM_MASTER_RDBACK_EN
            rsp_err_q   <= 1'b0;
            vfy_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
`ifdef BRAM_MASTER_RDBACK_EN
            rsp_err_q   <= rsp_err_d;
            vfy_q       <= vfy_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_we_d    = mem_we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
`ifdef BRAM_MASTER_RDBACK_EN
        rsp_err_d   = rsp_err_q;
        vfy_d       = vfy_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
`ifdef BRAM_MASTER_RDBACK_EN
                    vfy_d   = cmd_we;
`endif
                    if (cmd_we) begin
                        mem_we_d = 1'b1;
                        state_d  = WR;
                    end else begin
                        mem_we_d = 1'b0;
                        state_d  = RD_ADDR;
                    end
                end
            end
            WR: begin
                mem_we_d = 1'b0;
`ifdef BRAM_MASTER_RDBACK_EN
                state_d  = RD_ADDR;
`else
                rsp_valid_d = 1'b1;
                rsp_data_d  = wdata_q;
                state_d     = RSP;
`endif
            end
            RD_ADDR: begin
                state_d = RD_DATA;
            end
            RD_DATA: begin
                // RAM drives its registered word this cycle; mem_we is already low.
                rsp_valid_d = 1'b1;
                rsp_data_d  = mem_data;
`ifdef BRAM_MASTER_RDBACK_EN
                rsp_err_d   = vfy_q && (mem_data != wdata_q);
`endif
                state_d     = RSP;
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                mem_we_d    = 1'b0;
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bram_master.sv
// Self-checking bench for bram_master with a behavioural single-port RAM on the shared bus.
// Honours BRAM_MASTER_RDBACK_EN for write latency, read-back data and the stuck-bit test.
module tb_bram_master;

    localparam int W = 8;
    localparam int DEPTH = 256;
    localparam int AW = 8;

`ifdef BRAM_MASTER_RDBACK_EN
    localparam bit RDBACK = 1'b1;
`else
    localparam bit RDBACK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_we = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [W-1:0]  cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [W-1:0]  rsp_data;
    logic          rsp_err;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    wire  [W-1:0]  mem_data;

    bram_master #(.WIDTH(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data)
    );

    // clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: synchronous write and registered read; stuck_mask forces read bits to 1
    logic [W-1:0] ram [DEPTH];
    logic [W-1:0] ram_q = '0;
    logic [W-1:0] stuck_mask = '0;
    assign mem_data = mem_we ? {W{1'bz}} : ram_q;
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_data;
        ram_q <= ram[mem_addr] | stuck_mask;
    end

    // scoreboard
    logic [W-1:0] exp_q[$];
    logic         err_q[$];
    int           lat_q[$];
    int           acc_q[$];
    logic [W-1:0] shadow [DEPTH];
    logic [W-1:0] wr_exp = '0;
    bit           busy = 1'b0;
    bit           seen = 1'b0;
    int           n_checks = 0;
    int           n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic check_reset();
        check_eq("rst_cmd_ready", cmd_ready, 1);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_rsp_data", rsp_data, 0);
        check_eq("rst_rsp_err", rsp_err, 0);
        check_eq("rst_mem_we", mem_we, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
    endtask

    task automatic flush_sb();
        exp_q.delete(); err_q.delete(); lat_q.delete(); acc_q.delete();
        busy = 1'b0;
        seen = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check_eq("idle_timeout", cmd_ready, 1);
    endtask

    // drive one command; returns one tick after the accept edge
    task automatic do_cmd(input logic we, input logic [AW-1:0] addr, input logic [W-1:0] data);
        logic [W-1:0] rb;
        wait_idle();
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = data;
        if (we) begin
            shadow[addr] = data;
            wr_exp = data;
            rb = data | stuck_mask;
            exp_q.push_back(RDBACK ? rb : data);
            err_q.push_back(RDBACK ? (rb != data) : 1'b0);
            lat_q.push_back(RDBACK ? 3 : 1);
        end else begin
            exp_q.push_back(shadow[addr] | stuck_mask);
            err_q.push_back(1'b0);
            lat_q.push_back(2);
        end
        @(posedge clk);
        #1;
        acc_q.push_back(cyc);
        busy = 1'b1;
        cmd_valid = 1'b0;
    endtask

    // monitor: compares responses against the expected queue every cycle while valid
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) check_eq("cmd_ready_busy", cmd_ready, 0);
            if (mem_we) check_eq("bus_wr_data", mem_data, wr_exp);
            if (rsp_valid) begin
                check_eq("rsp_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0 && acc_q.size() != 0) begin
                    if (!seen) begin
                        check_eq("latency", cyc - acc_q[0], lat_q[0]);
                        seen = 1'b1;
                    end
                    check_eq("rsp_data", rsp_data, exp_q[0]);
                    check_eq("rsp_err", rsp_err, err_q[0]);
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        void'(err_q.pop_front());
                        void'(lat_q.pop_front());
                        void'(acc_q.pop_front());
                        seen = 1'b0;
                        busy = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] old;
        int n;
        for (int i = 0; i < DEPTH; i++) begin
            ram[i] = W'(i ^ 8'h33);
            shadow[i] = W'(i ^ 8'h33);
        end

        repeat (3) @(posedge clk);
        #1;
        check_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // basic write then read
        do_cmd(1'b1, 8'h10, 8'hA5);
        do_cmd(1'b0, 8'h10, 8'h00);

        // address boundaries, back to back
        do_cmd(1'b1, 8'h00, 8'h3E);
        do_cmd(1'b1, 8'hFF, 8'hC1);
        do_cmd(1'b0, 8'h00, 8'h00);
        do_cmd(1'b0, 8'hFF, 8'h00);

        // random traffic
        for (int i = 0; i < 12; i++)
            do_cmd(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

        // hold rsp_ready low on a read of 0x3C; a competing write must not be accepted
        do_cmd(1'b1, 8'h3C, 8'h3C);
        wait_idle();
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        do_cmd(1'b0, 8'h3C, 8'h00);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("hold_rsp_valid_seen", rsp_valid, 1);
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 8'h50; cmd_wdata = 8'hEE;
        repeat (5) @(posedge clk);
        #1;
        check_eq("hold_rsp_valid", rsp_valid, 1);
        check_eq("hold_rsp_data", rsp_data, 8'h3C);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        do_cmd(1'b0, 8'h50, 8'h00);

        // reset during RD_DATA
        do_cmd(1'b0, 8'h10, 8'h00);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset();
        flush_sb();
        @(negedge clk);
        rst_n = 1'b1;
        do_cmd(1'b0, 8'h10, 8'h00);

        // reset while a response is pending
        wait_idle();
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        do_cmd(1'b0, 8'hFF, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        check_eq("rsp_pending_before_rst", rsp_valid, 1);
        rst_n = 1'b0;
        #1;
        check_reset();
        flush_sb();
        rsp_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        do_cmd(1'b1, 8'h11, 8'h96);
        do_cmd(1'b0, 8'h11, 8'h00);

        // reset before the write edge: RAM must keep its old content
        old = shadow[8'h20];
        do_cmd(1'b1, 8'h20, 8'h77);
        rst_n = 1'b0;
        #1;
        check_reset();
        flush_sb();
        shadow[8'h20] = old;
        @(negedge clk);
        rst_n = 1'b1;
        do_cmd(1'b0, 8'h20, 8'h00);

`ifdef BRAM_MASTER_RDBACK_EN
        // read-back verify with a stuck data bit, then clean
        wait_idle();
        stuck_mask = 8'h01;
        do_cmd(1'b1, 8'h40, 8'h5A);
        wait_idle();
        stuck_mask = 8'h00;
        do_cmd(1'b1, 8'h41, 8'h5A);
`endif

        wait_idle();
        repeat (2) @(negedge clk);
        check_eq("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
